// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered, mutually aligned sync and blank flags.
// Optional start-of-frame pulse output `sof` is built only when VGA_TIMING_SOF_EN is defined.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int COUNT_W  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
`ifdef VGA_TIMING_SOF_EN
    output logic               vblnk,
    output logic               sof
`else
    output logic               vblnk
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COUNT_W-1:0] H_LAST     = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST     = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] H_BLNK_BEG = COUNT_W'(H_ACTIVE);
    localparam logic [COUNT_W-1:0] V_BLNK_BEG = COUNT_W'(V_ACTIVE);
    localparam logic [COUNT_W-1:0] H_SYNC_BEG = COUNT_W'(H_ACTIVE + H_FP);
    localparam logic [COUNT_W-1:0] H_SYNC_END = COUNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COUNT_W-1:0] V_SYNC_BEG = COUNT_W'(V_ACTIVE + V_FP);
    localparam logic [COUNT_W-1:0] V_SYNC_END = COUNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COUNT_W-1:0] hcount_nxt;
    logic [COUNT_W-1:0] vcount_nxt;

    always_comb begin
        hcount_nxt = hcount + 1'b1;
        vcount_nxt = vcount;
        if (hcount == H_LAST) begin
            hcount_nxt = '0;
            vcount_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end
    end

    // Flags are decoded from the next counter values so they land in the same register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            hblnk  <= 1'b0;
            vblnk  <= 1'b0;
        end else if (ce) begin
            hcount <= hcount_nxt;
            vcount <= vcount_nxt;
            hsync  <= (hcount_nxt >= H_SYNC_BEG) && (hcount_nxt < H_SYNC_END);
            vsync  <= (vcount_nxt >= V_SYNC_BEG) && (vcount_nxt < V_SYNC_END);
            hblnk  <= (hcount_nxt >= H_BLNK_BEG);
            vblnk  <= (vcount_nxt >= V_BLNK_BEG);
        end
    end

`ifdef VGA_TIMING_SOF_EN
    // Pulses only on the enabled cycle that wraps into 0/0; reset alone does not raise it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof <= 1'b0;
        end else if (ce) begin
            sof <= (hcount_nxt == '0) && (vcount_nxt == '0);
        end
    end
`endif

endmodule
